pll_reset_seq: RTL and testbench

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

---
 rtl/pll_reset_seq.sv | 180 ++++++++++++++++++
 tb/tb_pll_reset_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_seq.sv
`default_nettype none
//==============================================================================
// Module      : pll_reset_seq
// Description : PLL bring-up sequencer. Pulses the PLL reset, waits for a
//               synchronised lock, requires a stable lock window, then
//               releases the downstream reset. Timed-out attempts are retried
//               up to RETRY_MAX times before the sequencer parks in FAILED.
//               PWRDWN_REQ powers the PLL down from any state.
// Options     : define PLL_RESET_SEQ_RELOCK_EN to relock automatically when
//               lock is lost in RUN; otherwise loss of lock goes to FAILED.
// Revision    : 1.0 - initial release
//==============================================================================
module pll_reset_seq #(
   parameter int unsigned RST_PULSE_CYCLES   = 16,
   parameter int unsigned LOCK_TIMEOUT       = 4096,
   parameter int unsigned LOCK_STABLE_CYCLES = 8,
   parameter int unsigned RETRY_MAX          = 3
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       LOCKED,
   input  logic       PWRDWN_REQ,
   output logic       PLL_RST,
   output logic       PLL_PWRDWN,
   output logic       SYS_RST_N,
   output logic       READY,
   output logic       FAIL,
   output logic [3:0] RETRY_CNT
);

   typedef enum logic [2:0] {
      ST_PWRDN      = 3'd0,
      ST_ASSERT_RST = 3'd1,
      ST_WAIT_LOCK  = 3'd2,
      ST_STABLE     = 3'd3,
      ST_RUN        = 3'd4,
      ST_FAILED     = 3'd5
   } state_t;

   // Terminal counts: a counter value of N-1 marks the Nth cycle in state.
   localparam logic [15:0] c_rst_last     = 16'(RST_PULSE_CYCLES - 1);
   localparam logic [15:0] c_timeout_last = 16'(LOCK_TIMEOUT - 1);
   localparam logic [15:0] c_stable_last  = 16'(LOCK_STABLE_CYCLES - 1);
   localparam logic [3:0]  c_retry_max    = 4'(RETRY_MAX);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  retry_q, retry_d;
   logic        lock_meta_q, lock_meta_d;
   logic        lock_s_q, lock_s_d;
   logic        pll_rst_q, pll_rst_d;
   logic        pll_pwrdwn_q, pll_pwrdwn_d;
   logic        sys_rst_n_q, sys_rst_n_d;
   logic        ready_q, ready_d;
   logic        fail_q, fail_d;

   // Next-state, counters, synchroniser inputs and registered output values.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      retry_d     = retry_q;
      lock_meta_d = LOCKED;
      lock_s_d    = lock_meta_q;

      case (state_q)
         ST_ASSERT_RST: begin
            if (cnt_q == c_rst_last) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_WAIT_LOCK: begin
            // Lock seen on the timeout cycle takes precedence over the retry.
            if (lock_s_q) begin
               // The detecting cycle is the first stable cycle.
               cnt_d   = 16'd1;
               state_d = (LOCK_STABLE_CYCLES == 1) ? ST_RUN : ST_STABLE;
            end else if (cnt_q == c_timeout_last) begin
               cnt_d = '0;
               if (retry_q < c_retry_max) begin
                  retry_d = retry_q + 4'd1;
                  state_d = ST_ASSERT_RST;
               end else begin
                  state_d = ST_FAILED;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_STABLE: begin
            if (!lock_s_q) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == c_stable_last) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_RUN: begin
            if (!lock_s_q) begin
`ifdef PLL_RESET_SEQ_RELOCK_EN
               state_d = ST_ASSERT_RST;
               cnt_d   = '0;
               retry_d = '0;
`else
               state_d = ST_FAILED;
`endif
            end
         end
         ST_FAILED: begin
            state_d = ST_FAILED;
         end
         ST_PWRDN: begin
            if (!PWRDWN_REQ) begin
               state_d = ST_ASSERT_RST;
               cnt_d   = '0;
               retry_d = '0;
            end
         end
         default: begin
            state_d = ST_ASSERT_RST;
            cnt_d   = '0;
         end
      endcase

      // Power-down request overrides every other transition.
      if (PWRDWN_REQ) begin
         state_d = ST_PWRDN;
         cnt_d   = '0;
      end

      // Outputs decoded from the next state so they change with the state.
      pll_rst_d    = (state_d == ST_ASSERT_RST) || (state_d == ST_FAILED) ||
                     (state_d == ST_PWRDN);
      pll_pwrdwn_d = (state_d == ST_PWRDN);
      sys_rst_n_d  = (state_d == ST_RUN);
      ready_d      = (state_d == ST_RUN);
      fail_d       = (state_d == ST_FAILED);
   end

   // State, counters, synchroniser and output registers with async reset.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= ST_ASSERT_RST;
         cnt_q        <= '0;
         retry_q      <= '0;
         lock_meta_q  <= 1'b0;
         lock_s_q     <= 1'b0;
         pll_rst_q    <= 1'b1;
         pll_pwrdwn_q <= 1'b0;
         sys_rst_n_q  <= 1'b0;
         ready_q      <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         retry_q      <= retry_d;
         lock_meta_q  <= lock_meta_d;
         lock_s_q     <= lock_s_d;
         pll_rst_q    <= pll_rst_d;
         pll_pwrdwn_q <= pll_pwrdwn_d;
         sys_rst_n_q  <= sys_rst_n_d;
         ready_q      <= ready_d;
         fail_q       <= fail_d;
      end
   end

   assign PLL_RST    = pll_rst_q;
   assign PLL_PWRDWN = pll_pwrdwn_q;
   assign SYS_RST_N  = sys_rst_n_q;
   assign READY      = ready_q;
   assign FAIL       = fail_q;
   assign RETRY_CNT  = retry_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_seq.sv
`default_nettype none
//==============================================================================
// Module      : tb_pll_reset_seq
// Description : Directed self-checking bench for pll_reset_seq with
//               LOCK_TIMEOUT=20 and all other parameters at default.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_pll_reset_seq;

   logic       clk;
   logic       rst_n;
   logic       locked;
   logic       pwrdwn_req;
   logic       pll_rst;
   logic       pll_pwrdwn;
   logic       sys_rst_n;
   logic       ready;
   logic       fail;
   logic [3:0] retry_cnt;

   int checks = 0;
   int errors = 0;

   pll_reset_seq #(
      .RST_PULSE_CYCLES  (16),
      .LOCK_TIMEOUT      (20),
      .LOCK_STABLE_CYCLES(8),
      .RETRY_MAX         (3)
   ) dut (
      .CLK       (clk),
      .RST_N     (rst_n),
      .LOCKED    (locked),
      .PWRDWN_REQ(pwrdwn_req),
      .PLL_RST   (pll_rst),
      .PLL_PWRDWN(pll_pwrdwn),
      .SYS_RST_N (sys_rst_n),
      .READY     (ready),
      .FAIL      (fail),
      .RETRY_CNT (retry_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Edges until PLL_RST leaves the given level (bounded at 300).
   task automatic count_level(input logic lvl, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (pll_rst === lvl && n < 300);
   endtask

   // Reset held across two edges, released between edges.
   task automatic apply_reset();
      rst_n      = 1'b0;
      locked     = 1'b0;
      pwrdwn_req = 1'b0;
      ticks(2);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      locked     = 1'b0;
      pwrdwn_req = 1'b0;
      ticks(2);
      checks++;
      if ({pll_rst, pll_pwrdwn, sys_rst_n, ready, fail, retry_cnt} !== 9'b1_0000_0000) begin
         errors++;
         $display("FAIL reset_values: got %b expected %b",
                  {pll_rst, pll_pwrdwn, sys_rst_n, ready, fail, retry_cnt}, 9'b1_0000_0000);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_lock();
      int n;
      apply_reset();
      count_level(1'b1, n);
      checks++;
      if (n !== 16) begin errors++; $display("FAIL lock_first_pulse: got %0d expected 16", n); end
      ticks(10);
      locked = 1'b1;
      ticks(9);
      checks++;
      if ({ready, sys_rst_n} !== 2'b00) begin
         errors++; $display("FAIL lock_early_ready: got %b expected 00", {ready, sys_rst_n});
      end
      tick();
      checks++;
      if ({ready, sys_rst_n, pll_rst, fail} !== 4'b1100) begin
         errors++; $display("FAIL lock_ready: got %b expected 1100", {ready, sys_rst_n, pll_rst, fail});
      end
      checks++;
      if (retry_cnt !== 4'd0) begin errors++; $display("FAIL lock_retry: got %0d expected 0", retry_cnt); end
   endtask

   task automatic test_glitch();
      int n;
      apply_reset();
      count_level(1'b1, n);
      locked = 1'b1;
      ticks(5);
      locked = 1'b0;
      ticks(3);
      locked = 1'b1;
      ticks(2);
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL glitch_orig_point: got %b expected 0", ready); end
      ticks(7);
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL glitch_pre_ready: got %b expected 0", ready); end
      tick();
      checks++;
      if ({ready, sys_rst_n} !== 2'b11) begin
         errors++; $display("FAIL glitch_ready: got %b expected 11", {ready, sys_rst_n});
      end
   endtask

   task automatic test_timeout();
      int n;
      apply_reset();
      for (int a = 0; a < 4; a++) begin
         count_level(1'b1, n);
         checks++;
         if (n !== 16) begin errors++; $display("FAIL timeout_pulse%0d: got %0d expected 16", a, n); end
         count_level(1'b0, n);
         checks++;
         if (n !== 20) begin errors++; $display("FAIL timeout_wait%0d: got %0d expected 20", a, n); end
         checks++;
         if (retry_cnt !== ((a < 3) ? 4'(a + 1) : 4'd3)) begin
            errors++; $display("FAIL timeout_retry%0d: got %0d expected %0d", a, retry_cnt, (a < 3) ? a + 1 : 3);
         end
         checks++;
         if (fail !== (a == 3)) begin errors++; $display("FAIL timeout_flag%0d: got %b expected %b", a, fail, a == 3); end
      end
      ticks(40);
      checks++;
      if ({fail, pll_rst, ready, sys_rst_n, retry_cnt} !== 8'b1100_0011) begin
         errors++; $display("FAIL timeout_parked: got %b expected 11000011", {fail, pll_rst, ready, sys_rst_n, retry_cnt});
      end
   endtask

   task automatic test_pwrdwn();
      int n;
      apply_reset();
      count_level(1'b1, n);
      count_level(1'b0, n);
      count_level(1'b1, n);
      checks++;
      if (retry_cnt !== 4'd1) begin errors++; $display("FAIL pwrdwn_pre_retry: got %0d expected 1", retry_cnt); end
      ticks(3);
      pwrdwn_req = 1'b1;
      tick();
      checks++;
      if ({pll_pwrdwn, pll_rst, sys_rst_n, ready} !== 4'b1100) begin
         errors++; $display("FAIL pwrdwn_enter: got %b expected 1100", {pll_pwrdwn, pll_rst, sys_rst_n, ready});
      end
      ticks(4);
      pwrdwn_req = 1'b0;
      tick();
      checks++;
      if ({pll_pwrdwn, pll_rst, retry_cnt} !== 6'b01_0000) begin
         errors++; $display("FAIL pwrdwn_exit: got %b expected 010000", {pll_pwrdwn, pll_rst, retry_cnt});
      end
      count_level(1'b1, n);
      checks++;
      if (n !== 16) begin errors++; $display("FAIL pwrdwn_pulse: got %0d expected 16", n); end
   endtask

   task automatic test_run_loss();
      int n;
      apply_reset();
      count_level(1'b1, n);
      locked = 1'b1;
      n = 0;
      while (ready !== 1'b1 && n < 50) begin tick(); n++; end
      checks++;
      if (ready !== 1'b1) begin errors++; $display("FAIL run_bringup: got %b expected 1", ready); end
      locked = 1'b0;
      ticks(2);
      checks++;
      if (ready !== 1'b1) begin errors++; $display("FAIL run_sync_delay: got %b expected 1", ready); end
      tick();
`ifdef PLL_RESET_SEQ_RELOCK_EN
      checks++;
      if ({pll_rst, sys_rst_n, ready, fail, retry_cnt} !== 8'b1000_0000) begin
         errors++; $display("FAIL run_relock_enter: got %b expected 10000000", {pll_rst, sys_rst_n, ready, fail, retry_cnt});
      end
      count_level(1'b1, n);
      checks++;
      if (n !== 16) begin errors++; $display("FAIL run_relock_pulse: got %0d expected 16", n); end
      locked = 1'b1;
      ticks(10);
      checks++;
      if ({ready, sys_rst_n, retry_cnt} !== 6'b11_0000) begin
         errors++; $display("FAIL run_relock_ready: got %b expected 110000", {ready, sys_rst_n, retry_cnt});
      end
`else
      checks++;
      if ({fail, pll_rst, sys_rst_n, ready} !== 4'b1100) begin
         errors++; $display("FAIL run_loss_failed: got %b expected 1100", {fail, pll_rst, sys_rst_n, ready});
      end
      locked = 1'b1;
      ticks(15);
      checks++;
      if ({fail, ready} !== 2'b10) begin
         errors++; $display("FAIL run_loss_sticky: got %b expected 10", {fail, ready});
      end
`endif
   endtask

   task automatic test_async_reset();
      int n;
      apply_reset();
      count_level(1'b1, n);
      count_level(1'b0, n);
      count_level(1'b1, n);
      ticks(4);
      checks++;
      if ({pll_rst, retry_cnt} !== 5'b0_0001) begin
         errors++; $display("FAIL async_pre: got %b expected 00001", {pll_rst, retry_cnt});
      end
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({pll_rst, pll_pwrdwn, sys_rst_n, ready, fail, retry_cnt} !== 9'b1_0000_0000) begin
         errors++;
         $display("FAIL async_reset: got %b expected %b",
                  {pll_rst, pll_pwrdwn, sys_rst_n, ready, fail, retry_cnt}, 9'b1_0000_0000);
      end
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_lock();
      test_glitch();
      test_timeout();
      test_pwrdwn();
      test_run_loss();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
